// File: rtl/wishbone_to_axi4lite_pkg.sv
// wishbone_to_axi4lite_pkg: AXI response codes, bridge FSM encoding and protection default
package wishbone_to_axi4lite_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  function automatic logic resp_is_err(input logic [1:0] r);
    return r == RESP_SLVERR || r == RESP_DECERR;
  endfunction
endpackage

// File: rtl/wishbone_to_axi4lite.sv
// wishbone_to_axi4lite: Wishbone classic slave to AXI4-lite master, one outstanding transfer
module wishbone_to_axi4lite
  import wishbone_to_axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
  output logic [2:0]              axi_awprot_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [DATA_WIDTH-1:0]   axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o,
  output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
  output logic [2:0]              axi_arprot_o,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic abort, resp_err, req, aw_done, w_done;
  assign req = wb_cyc_i & wb_stb_i;
  assign aw_done = ~axi_awvalid_o | axi_awready_i;
  assign w_done = ~axi_wvalid_o | axi_wready_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE:    state_n = req ? (wb_we_i ? WR : RD_ADDR) : IDLE;
      WR:      state_n = aw_done & w_done ? WR_RESP : WR;
      WR_RESP: state_n = axi_bvalid_i ? DONE : WR_RESP;
      RD_ADDR: state_n = axi_arready_i ? RD_DATA : RD_ADDR;
      RD_DATA: state_n = axi_rvalid_i ? DONE : RD_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      axi_awvalid_o <= 1'b0;
      axi_wvalid_o <= 1'b0;
      axi_arvalid_o <= 1'b0;
      wb_dat_o <= '0;
      resp_err <= 1'b0;
      abort <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        axi_awvalid_o <= wb_we_i;
        axi_wvalid_o <= wb_we_i;
        axi_arvalid_o <= ~wb_we_i;
      end
      if (state == WR && axi_awready_i) axi_awvalid_o <= 1'b0;
      if (state == WR && axi_wready_i) axi_wvalid_o <= 1'b0;
      if (state == RD_ADDR && axi_arready_i) axi_arvalid_o <= 1'b0;
      if (state == WR_RESP && axi_bvalid_i) resp_err <= resp_is_err(axi_bresp_i);
      if (state == RD_DATA && axi_rvalid_i) begin
        resp_err <= resp_is_err(axi_rresp_i);
        wb_dat_o <= axi_rdata_i;
      end
      // a dropped cyc anywhere in flight suppresses the final ack/err
      abort <= state == IDLE ? 1'b0 : state == DONE ? abort : abort | ~wb_cyc_i;
    end
  assign wb_ack_o = state == DONE && !abort && !resp_err;
  assign wb_err_o = state == DONE && !abort && resp_err;
  assign axi_bready_o = state == WR_RESP;
  assign axi_rready_o = state == RD_DATA;
  assign axi_awaddr_o = adr_q;
  assign axi_araddr_o = adr_q;
  assign axi_wdata_o = dat_q;
  assign axi_wstrb_o = sel_q;
  assign axi_awprot_o = PROT_DEFAULT;
  assign axi_arprot_o = PROT_DEFAULT;
endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// tb_wishbone_to_axi4lite: scoreboard bench driving Wishbone requests against scripted AXI slaves
module tb_wishbone_to_axi4lite;
  logic clk = 0, rst = 1;
  logic cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic [3:0] sel = 0;
  logic ack, err;
  logic [31:0] awaddr, wdata, araddr;
  logic [31:0] rdata = 0;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, wvalid, arvalid, bready, rready;
  logic awready = 0, wready = 0, arready = 0, bvalid = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  int total = 0, bad = 0, last_lat = 0;
  typedef struct packed {logic err; logic chk; logic [31:0] dat;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  wishbone_to_axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
    .axi_awaddr_o(awaddr), .axi_awprot_o(awprot), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_araddr_o(araddr), .axi_arprot_o(arprot), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );
  task automatic wb_issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic e, input logic [31:0] x);
    exp_t t;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    t.err = e; t.chk = !w && !e; t.dat = x;
    sb.push_back(t);
  endtask
  task automatic wb_wait(input string nm);
    exp_t t;
    int n = 0;
    do begin @(negedge clk); n++; end while (!(ack || err) && n < 100);
    last_lat = n;
    t = sb.size() != 0 ? sb.pop_front() : '0;
    total++;
    if (ack !== !t.err || err !== t.err) begin
      bad++;
      $display("FAIL %s: ack=%b err=%b, required ack=%b err=%b", nm, ack, err, !t.err, t.err);
    end
    if (t.chk) begin
      total++;
      if (rdat !== t.dat) begin bad++; $display("FAIL %s data: got %h, required %h", nm, rdat, t.dat); end
    end
    cyc = 0; stb = 0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL %s pulse: ack=%b err=%b one cycle later, required 0 0", nm, ack, err);
    end
  endtask
  task automatic slave_aw(input int dly, input logic [31:0] ea);
    int n = 0;
    while (awvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (dly) @(negedge clk);
    total++;
    if (awvalid !== 1'b1 || awaddr !== ea || awprot !== 3'b000) begin
      bad++; $display("FAIL aw: valid=%b addr=%h prot=%h, required 1 %h 0", awvalid, awaddr, awprot, ea);
    end
    awready = 1; @(negedge clk); awready = 0;
    total++;
    if (awvalid !== 1'b0) begin bad++; $display("FAIL aw drop: awvalid=%b after handshake, required 0", awvalid); end
  endtask
  task automatic slave_w(input int dly, input logic [31:0] ed, input logic [3:0] es);
    int n = 0;
    while (wvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (dly) @(negedge clk);
    total++;
    if (wvalid !== 1'b1 || wdata !== ed || wstrb !== es) begin
      bad++; $display("FAIL w: valid=%b data=%h strb=%h, required 1 %h %h", wvalid, wdata, wstrb, ed, es);
    end
    wready = 1; @(negedge clk); wready = 0;
    total++;
    if (wvalid !== 1'b0) begin bad++; $display("FAIL w drop: wvalid=%b after handshake, required 0", wvalid); end
  endtask
  task automatic slave_b(input int dly, input logic [1:0] r);
    int n = 0;
    logic hs;
    repeat (dly) @(negedge clk);
    bvalid = 1; bresp = r;
    do begin hs = bready; @(negedge clk); n++; end while (!hs && n < 100);
    bvalid = 0;
    total++;
    if (!hs) begin bad++; $display("FAIL b: bready=0 for 100 cycles, required 1"); end
  endtask
  task automatic slave_ar(input int dly, input logic [31:0] ea);
    int n = 0;
    while (arvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (dly) @(negedge clk);
    total++;
    if (arvalid !== 1'b1 || araddr !== ea || arprot !== 3'b000) begin
      bad++; $display("FAIL ar: valid=%b addr=%h prot=%h, required 1 %h 0", arvalid, araddr, arprot, ea);
    end
    arready = 1; @(negedge clk); arready = 0;
    total++;
    if (arvalid !== 1'b0) begin bad++; $display("FAIL ar drop: arvalid=%b after handshake, required 0", arvalid); end
  endtask
  task automatic slave_r(input int dly, input logic [31:0] d, input logic [1:0] r);
    int n = 0;
    logic hs;
    repeat (dly) @(negedge clk);
    rvalid = 1; rdata = d; rresp = r;
    do begin hs = rready; @(negedge clk); n++; end while (!hs && n < 100);
    rvalid = 0;
    total++;
    if (!hs) begin bad++; $display("FAIL r: rready=0 for 100 cycles, required 1"); end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({ack, err, awvalid, wvalid, arvalid, bready, rready} !== 7'b0) begin
      bad++; $display("FAIL reset ctrl: %b, required 0000000", {ack, err, awvalid, wvalid, arvalid, bready, rready});
    end
    total++;
    if (rdat !== 32'h0 || awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0) begin
      bad++; $display("FAIL reset data: dat=%h awaddr=%h wdata=%h wstrb=%h, required all 0", rdat, awaddr, wdata, wstrb);
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_write_zero_wait();
    wb_issue(1, 32'h40000010, 32'hDEADBEEF, 4'hF, 0, 0);
    fork
      begin fork slave_aw(0, 32'h40000010); slave_w(0, 32'hDEADBEEF, 4'hF); join slave_b(0, 2'b00); end
      wb_wait("write_zero_wait");
    join
    total++;
    if (last_lat != 3) begin bad++; $display("FAIL write latency: ack in cycle %0d, required 3", last_lat); end
  endtask
  task automatic test_write_skew();
    wb_issue(1, 32'h40000014, 32'h0BADCAFE, 4'h6, 0, 0);
    fork
      begin
        fork
          begin
            slave_w(0, 32'h0BADCAFE, 4'h6);
            total++;
            if (awvalid !== 1'b1 || bready !== 1'b0) begin
              bad++; $display("FAIL skew: awvalid=%b bready=%b after W only, required 1 0", awvalid, bready);
            end
          end
          slave_aw(4, 32'h40000014);
        join
        slave_b(2, 2'b01);
      end
      wb_wait("write_skew");
    join
    total++;
    if (last_lat != 9) begin bad++; $display("FAIL skew latency: ack in cycle %0d, required 9", last_lat); end
  endtask
  task automatic test_read_wait();
    wb_issue(0, 32'h40000004, 0, 4'hF, 0, 32'h12345678);
    fork
      begin slave_ar(0, 32'h40000004); slave_r(3, 32'h12345678, 2'b00); end
      wb_wait("read_wait");
    join
    wb_issue(1, 32'h40000008, 32'h55AA55AA, 4'hF, 0, 0);
    fork
      begin fork slave_aw(0, 32'h40000008); slave_w(0, 32'h55AA55AA, 4'hF); join slave_b(0, 2'b00); end
      wb_wait("write_after_read");
    join
    total++;
    if (rdat !== 32'h12345678) begin bad++; $display("FAIL read hold: dat=%h after write, required 12345678", rdat); end
  endtask
  task automatic test_errors();
    wb_issue(0, 32'h4000000C, 0, 4'hF, 1, 0);
    fork
      begin slave_ar(1, 32'h4000000C); slave_r(0, 32'hBAD0BAD0, 2'b10); end
      wb_wait("read_slverr");
    join
    wb_issue(1, 32'h40000018, 32'h11223344, 4'h1, 1, 0);
    fork
      begin fork slave_aw(1, 32'h40000018); slave_w(2, 32'h11223344, 4'h1); join slave_b(1, 2'b11); end
      wb_wait("write_decerr");
    join
  endtask
  task automatic test_abort();
    int n, hits;
    logic bdone;
    bdone = 0; hits = 0; n = 0;
    cyc = 1; stb = 1; we = 1; adr = 32'h40000020; wdat = 32'hA5A5A5A5; sel = 4'h3;
    fork
      begin
        fork slave_aw(0, 32'h40000020); slave_w(0, 32'hA5A5A5A5, 4'h3); join
        slave_b(6, 2'b00);
        bdone = 1;
      end
      begin
        repeat (3) @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);
        total++;
        if (bready !== 1'b1) begin bad++; $display("FAIL abort bready: %b after cyc drop, required 1", bready); end
        wb_issue(0, 32'h40000030, 0, 4'hF, 0, 32'hCAFEF00D);
        while (arvalid !== 1'b1 && n < 40) begin
          if (ack || err) hits++;
          @(negedge clk); n++;
        end
        total++;
        if (arvalid !== 1'b1 || !bdone || hits != 0) begin
          bad++; $display("FAIL abort: arvalid=%b bdone=%b ack/err cycles=%0d, required 1 1 0", arvalid, bdone, hits);
        end
      end
    join
    fork
      begin slave_ar(0, 32'h40000030); slave_r(0, 32'hCAFEF00D, 2'b00); end
      wb_wait("read_after_abort");
    join
  endtask
  task automatic test_reset_mid_read();
    int n = 0;
    cyc = 1; stb = 1; we = 0; adr = 32'h40000040; sel = 4'hF;
    while (arvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (arvalid !== 1'b1) begin bad++; $display("FAIL mid read: arvalid=%b, required 1", arvalid); end
    #2 rst = 1;
    #1;
    total++;
    if ({ack, err, awvalid, wvalid, arvalid, bready, rready} !== 7'b0 || rdat !== 32'h0 || araddr !== 32'h0) begin
      bad++; $display("FAIL async reset: ctrl=%b dat=%h araddr=%h, required all 0",
                      {ack, err, awvalid, wvalid, arvalid, bready, rready}, rdat, araddr);
    end
    cyc = 0; stb = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    wb_issue(0, 32'h40000044, 0, 4'hF, 0, 32'h600DD00D);
    fork
      begin slave_ar(0, 32'h40000044); slave_r(1, 32'h600DD00D, 2'b01); end
      wb_wait("read_after_reset");
    join
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_skew();
    test_read_wait();
    test_errors();
    test_abort();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
